// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I single-cycle control path: opcodes, ALUOp,
// ALUControl and ImmSrc codes plus the main-decoder field bundle.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

endpackage

// File: rtl/alu_decoder.sv
// ALUOp/funct3/funct7 to ALUControl. Shifts and sltu are unsupported and fall back to add.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7,
  output logic [2:0] alu_control
);

  // Only R-type (op5=1) honours instr[30] as sub; addi ignores it
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000: begin
            if ({op5, funct7} == 2'b11) alu_control = ALU_SUB;
            else                        alu_control = ALU_ADD;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_decoder.sv
// Opcode to datapath control fields; unknown opcodes decode to all-zero controls.
module main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_t      ctrl
);

  // Opcode decode table
  always_comb begin
    ctrl = CTRL_NONE;
    case (op)
      OP_LW:   ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
      OP_SW:   ctrl = '{1'b0, IMM_S, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OP_R:    ctrl = '{1'b1, IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNC};
      OP_IALU: ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNC};
      OP_BEQ:  ctrl = '{1'b0, IMM_B, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB};
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle RV32I control unit: combinational decode with a run flag that
// holds the architectural write enables low until the first edge out of reset.
module control_unit
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCSrc,
  output logic       ResultSrc,
  output logic       MemWrite,
  output logic [2:0] ALUControl,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic       RegWrite
);

  ctrl_t ctrl_s;
  logic  run_q;

  main_decoder u_main_decoder (
    .op   (op),
    .ctrl (ctrl_s)
  );

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_s.alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7      (funct7),
    .alu_control (ALUControl)
  );

  // Run flag: the only state in the block
  always_ff @(posedge clk) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign ResultSrc = ctrl_s.result_src;
  assign ALUSrc    = ctrl_s.alu_src;
  assign ImmSrc    = ctrl_s.imm_src;
  assign RegWrite  = ctrl_s.reg_write & run_q;
  assign MemWrite  = ctrl_s.mem_write & run_q;
  assign PCSrc     = ctrl_s.branch & Zero & run_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with hand-computed expectations.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       PCSrc;
  logic       ResultSrc;
  logic       MemWrite;
  logic [2:0] ALUControl;
  logic       ALUSrc;
  logic [1:0] ImmSrc;
  logic       RegWrite;

  int total;
  int bad;

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .PCSrc      (PCSrc),
    .ResultSrc  (ResultSrc),
    .MemWrite   (MemWrite),
    .ALUControl (ALUControl),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7 = f7; Zero = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {PCSrc,ResultSrc,MemWrite,ALUControl,ALUSrc,ImmSrc,RegWrite}
  function automatic logic [15:0] all_out();
    return {6'd0, PCSrc, ResultSrc, MemWrite, ALUControl, ALUSrc, ImmSrc, RegWrite};
  endfunction

  logic [2:0] f3_tab  [8] = '{3'd2, 3'd6, 3'd7, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};
  logic [2:0] exp_tab [8] = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
  logic [6:0] sw_op   [4] = '{7'h13, 7'h13, 7'h33, 7'h33};
  logic       sw_f7   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0] sw_exp  [4] = '{3'b000, 3'b000, 3'b000, 3'b001};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(7'h03, 3'd0, 1'b0, 1'b1);
    tick();
    // Reset state: enables gated, datapath selects still decode
    check("rst_regwrite", {15'd0, RegWrite}, 16'd0);
    check("rst_alusrc", {15'd0, ALUSrc}, 16'd1);
    drive(7'h63, 3'd0, 1'b0, 1'b1);
    check("rst_pcsrc", {15'd0, PCSrc}, 16'd0);

    rst_n = 1'b1;
    tick();

    // 1: unknown op -> everything zero
    drive(7'h00, 3'd0, 1'b0, 1'b0);
    check("t1_zero_op", all_out(), 16'd0);
    drive(7'h7f, 3'd7, 1'b1, 1'b1);
    check("t1_other_op", all_out(), 16'd0);

    // 2: lw
    drive(7'h03, 3'd2, 1'b0, 1'b0);
    check("t2_lw", all_out(), {6'd0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 2'b00, 1'b1});

    // 3: sw
    drive(7'h23, 3'd2, 1'b0, 1'b0);
    check("t3_sw", all_out(), {6'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01, 1'b0});

    // 4: beq, Zero 0 then 1
    drive(7'h63, 3'd0, 1'b0, 1'b0);
    check("t4_beq_nz", all_out(), {6'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0});
    drive(7'h63, 3'd0, 1'b0, 1'b1);
    check("t4_beq_z", all_out(), {6'd0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0});
    drive(7'h33, 3'd0, 1'b0, 1'b1);
    check("t4_r_zero_nobranch", {15'd0, PCSrc}, 16'd0);

    // 5: {op[5],funct7} sweep with funct3=0
    for (int i = 0; i < 4; i++) begin
      drive(sw_op[i], 3'd0, sw_f7[i], 1'b0);
      check($sformatf("t5_aluctl_%0d", i), {13'd0, ALUControl}, {13'd0, sw_exp[i]});
      check($sformatf("t5_regwrite_%0d", i), {15'd0, RegWrite}, 16'd1);
    end
    drive(7'h13, 3'd0, 1'b1, 1'b0);
    check("t5_addi_alusrc", {15'd0, ALUSrc}, 16'd1);

    // 6: R-type funct3 table
    for (int i = 0; i < 8; i++) begin
      drive(7'h33, f3_tab[i], 1'b0, 1'b0);
      check($sformatf("t6_f3_%0d", f3_tab[i]), {13'd0, ALUControl}, {13'd0, exp_tab[i]});
    end
    drive(7'h13, 3'd7, 1'b0, 1'b0);
    check("t6_andi", {13'd0, ALUControl}, {13'd0, 3'b010});

    // 7: synchronous reset mid-run
    drive(7'h23, 3'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t7_memwrite_before_edge", {15'd0, MemWrite}, 16'd1);
    tick();
    check("t7_memwrite_in_rst", {15'd0, MemWrite}, 16'd0);
    check("t7_alusrc_sw", {15'd0, ALUSrc}, 16'd1);
    drive(7'h33, 3'd0, 1'b0, 1'b0);
    check("t7_regwrite_in_rst", {15'd0, RegWrite}, 16'd0);
    check("t7_alusrc_r", {15'd0, ALUSrc}, 16'd0);
    rst_n = 1'b1;
    #1;
    check("t7_regwrite_before_edge", {15'd0, RegWrite}, 16'd0);
    tick();
    check("t7_regwrite_after", {15'd0, RegWrite}, 16'd1);
    drive(7'h23, 3'd2, 1'b0, 1'b0);
    check("t7_memwrite_after", {15'd0, MemWrite}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
